// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide (radix-2 shift-add, restoring divide).
// Latency WIDTH+2 cycles, or 1 cycle for div-by-zero/overflow; ready_o only in IDLE, flush_i aborts with no done_o.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [2:0]       Funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]         state;
  logic [2:0]         func;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   quo;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     rem;
  logic               neg_res;
  logic               neg_r;
  logic [CNT_W-1:0]   cnt;

  logic             accept;
  logic             is_div, sgn_a, sgn_b, sa, sb;
  logic             div_zero, div_ovf, special;
  logic [WIDTH-1:0] mag_a, mag_b, special_res;

  assign ready_o = (state == IDLE);
  assign busy_o  = (state != IDLE);
  assign done_o  = (state == DONE);
  assign accept  = valid_i & ready_o & ~flush_i;

  // Operand decode at accept: signedness, magnitudes and the two shortcut cases.
  always_comb begin
    is_div = Funct3[2];
    sgn_a  = is_div ? ~Funct3[0] : (Funct3[1:0] != 2'b11);
    sgn_b  = is_div ? ~Funct3[0] : ~Funct3[1];
    sa     = sgn_a & op_a[WIDTH-1];
    sb     = sgn_b & op_b[WIDTH-1];
    mag_a  = sa ? -op_a : op_a;
    mag_b  = sb ? -op_b : op_b;
    div_zero = is_div & (op_b == '0);
    div_ovf  = is_div & ~Funct3[0] & (op_a == MIN_NEG) & (op_b == '1);
    special  = div_zero | div_ovf;
    if (div_zero) special_res = Funct3[1] ? op_a : '1;
    else          special_res = Funct3[1] ? '0 : op_a;
  end

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   div_sh, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix, fix_res;

  always_comb begin
    mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opnd} : '0);
    // Extra top bit of the trial difference acts as the borrow / restore flag.
    div_sh   = {rem, quo[WIDTH-1]};
    div_diff = div_sh - {2'b00, opnd};
    div_ge   = ~div_diff[WIDTH+1];
    prod_fix = neg_res ? -prod : prod;
    q_fix    = neg_res ? -quo : quo;
    r_fix    = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    if (func[2])                fix_res = func[1] ? r_fix : q_fix;
    else if (func[1:0] == 2'b00) fix_res = prod_fix[WIDTH-1:0];
    else                        fix_res = prod_fix[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      func     <= '0;
      opnd     <= '0;
      quo      <= '0;
      prod     <= '0;
      rem      <= '0;
      neg_res  <= 1'b0;
      neg_r    <= 1'b0;
      cnt      <= '0;
      result_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            func    <= Funct3;
            cnt     <= '0;
            neg_res <= sa ^ sb;
            neg_r   <= sa;
            rem     <= '0;
            if (is_div) begin
              opnd <= mag_b;
              quo  <= mag_a;
              prod <= '0;
            end else begin
              opnd <= mag_a;
              prod <= {{WIDTH{1'b0}}, mag_b};
              quo  <= '0;
            end
            if (special) begin
              result_o <= special_res;
              state    <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (flush_i) begin
            state <= IDLE;
          end else begin
            if (func[2]) begin
              rem <= div_ge ? div_diff[WIDTH:0] : div_sh[WIDTH:0];
              quo <= {quo[WIDTH-2:0], div_ge};
            end else begin
              prod <= {mul_sum, prod[WIDTH-1:1]};
            end
            cnt <= cnt + CNT_ONE;
            if (cnt == CNT_LAST) state <= FIX;
          end
        end
        FIX: begin
          if (flush_i) begin
            state <= IDLE;
          end else begin
            result_o <= fix_res;
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
